// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared command addresses, readback sizing, state type and checksum helper
package sa_ctrl_pkg;
  localparam logic [7:0] CMD_RIGHT_SHIFT  = 8'hFF;
  localparam logic [7:0] CMD_B_SHIFT      = 8'hFE;
  localparam logic [7:0] CMD_BOTTOM_SHIFT = 8'hFD;
  localparam logic [7:0] CMD_A_DATA       = 8'hFC;
  localparam logic [7:0] CMD_B_DATA       = 8'hFB;
  localparam logic [7:0] CMD_PS_DATA      = 8'hFA;
  localparam logic [7:0] CMD_READBACK     = 8'hF9;
  localparam int RB_DATA_BYTES = 8;
  typedef enum logic {IDLE, SEND} rb_state_t;
  function automatic logic [7:0] xor_bytes(input logic [63:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < RB_DATA_BYTES; i++) x ^= d[8*i +: 8];
    return x;
  endfunction
endpackage

// File: rtl/cmd_strobe_detect.sv
// cmd_strobe_detect: single-cycle hit on a uart_rw rising edge carrying the matching address
module cmd_strobe_detect
  import sa_ctrl_pkg::*;
#(
  parameter logic [7:0] ADDR = CMD_READBACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rw,
  input  logic [7:0] uart_in,
  output logic       hit
);
  logic rw_q;
  // previous strobe level so a held strobe only counts on its first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rw_q <= 1'b0;
    else rw_q <= uart_rw;
  end
  assign hit = uart_rw & ~rw_q & (uart_in == ADDR);
endmodule

// File: rtl/result_readback_module.sv
// result_readback_module: snapshots the partial sums on a readback command and streams them bytewise
module result_readback_module
  import sa_ctrl_pkg::*;
#(
  parameter logic [7:0] READ_ADDR     = CMD_READBACK,
  parameter logic       SEND_CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rw,
  input  logic [7:0]  uart_in,
  input  logic [15:0] ps_data0,
  input  logic [15:0] ps_data1,
  input  logic [15:0] ps_data2,
  input  logic [15:0] ps_data3,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam logic [3:0] LAST_IDX = SEND_CHECKSUM ? 4'd8 : 4'd7;
  rb_state_t state, state_n;
  logic [63:0] snap;
  logic [3:0] idx;
  logic [7:0] cur_byte;
  logic trig, xfer, final_xfer, accept;
  cmd_strobe_detect #(.ADDR(READ_ADDR)) u_det (
    .clk(clk),
    .rst(rst),
    .uart_rw(uart_rw),
    .uart_in(uart_in),
    .hit(trig)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state, handshake decode and byte mux; index 8 is the checksum slot
  always_comb begin
    tx_valid = state == SEND;
    accept = trig & ~tx_valid;
    xfer = tx_valid & tx_ready;
    final_xfer = xfer & (idx == LAST_IDX);
    state_n = accept ? SEND : final_xfer ? IDLE : state;
    cur_byte = idx[3] ? xor_bytes(snap) : snap[{idx[2:0], 3'b000} +: 8];
    tx_data = tx_valid ? cur_byte : 8'h00;
  end
  assign busy = tx_valid;
  // snapshot, byte index, completion pulse and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      idx     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= final_xfer;
      if (accept) begin
        snap    <= {ps_data3, ps_data2, ps_data1, ps_data0};
        idx     <= '0;
        overrun <= 1'b0;
      end else begin
        if (trig) overrun <= 1'b1;
        if (xfer) idx <= final_xfer ? 4'd0 : idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_result_readback_module.sv
// tb_result_readback_module: directed scenarios plus random traffic checked against a byte-queue model
module tb_result_readback_module;
  localparam logic CS = 1'b1;
  localparam int NB = CS ? 9 : 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rw, tx_ready, tx_valid, busy, done, overrun;
  logic [7:0] uart_in, tx_data;
  logic [15:0] ps0, ps1, ps2, ps3;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [9] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h00};
  logic [7:0] got [$];
  logic [7:0] q [$];
  logic m_prev = 1'b0;
  logic m_done = 1'b0;
  logic m_ovr = 1'b0;
  logic m_trg, m_xf;
  logic [7:0] m_cs;
  logic [15:0] m_w [4];

  always #5 clk = ~clk;

  result_readback_module #(.READ_ADDR(8'hF9), .SEND_CHECKSUM(CS)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rw(uart_rw),
    .uart_in(uart_in),
    .ps_data0(ps0),
    .ps_data1(ps1),
    .ps_data2(ps2),
    .ps_data3(ps3),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: a readback is a queue of pending bytes; a trigger while bytes are pending is an overrun
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_prev = 1'b0;
      m_done = 1'b0;
      m_ovr = 1'b0;
    end else begin
      m_trg = uart_rw && !m_prev && uart_in == 8'hF9;
      m_xf = q.size() > 0 && tx_ready;
      m_done = m_xf && q.size() == 1;
      if (m_trg) begin
        if (q.size() > 0) m_ovr = 1'b1;
        else begin
          m_w = '{ps0, ps1, ps2, ps3};
          m_cs = 8'h00;
          for (int i = 0; i < 4; i++) begin
            q.push_back(m_w[i][7:0]);
            q.push_back(m_w[i][15:8]);
            m_cs ^= m_w[i][7:0] ^ m_w[i][15:8];
          end
          if (CS) q.push_back(m_cs);
          m_ovr = 1'b0;
        end
      end
      if (m_xf) void'(q.pop_front());
      m_prev = uart_rw;
    end
  end

  always @(negedge clk) begin
    chk("tx_valid", tx_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("tx_data", tx_data, q.size() > 0 ? q[0] : 8'h00);
    chk("done", done, m_done);
    chk("overrun", overrun, m_ovr);
  end

  task automatic set_ps_lit();
    ps0 = 16'h1234; ps1 = 16'h5678; ps2 = 16'h9ABC; ps3 = 16'hDEF0;
  endtask

  task automatic trig(input logic [7:0] a);
    @(posedge clk); #1;
    uart_rw = 1'b1;
    uart_in = a;
  endtask

  task automatic collect(input int mode, input int hold, input int inj, input bit chg);
    bit lastx = 0;
    bit stall = 0;
    bit fin = 0;
    logic [7:0] sv = 8'h00;
    got.delete();
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge clk); #1;
      uart_rw = (c < hold) || (c == inj);
      uart_in = 8'hF9;
      tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      if (chg && c == 0) begin ps0 = 16'hFFFF; ps1 = 16'hFFFF; ps2 = 16'hFFFF; ps3 = 16'hFFFF; end
      @(negedge clk);
      if (lastx) begin
        chk("done_pulse", done, 1);
        fin = 1;
      end else begin
        if (stall) chk("stall_hold", tx_data, sv);
        stall = tx_valid && !tx_ready;
        sv = tx_data;
        if (tx_valid && tx_ready) begin
          got.push_back(tx_data);
          lastx = got.size() == NB;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL collect_timeout: done got 0 expected 1 within 60 cycles");
    end
    chk("byte_count", got.size(), NB);
    for (int i = 0; i < got.size() && i < NB; i++) chk($sformatf("byte%0d", i), got[i], exp_b[i]);
  endtask

  initial begin
    int n;
    uart_rw = 1'b0; uart_in = 8'h00; tx_ready = 1'b0;
    ps0 = 16'h0; ps1 = 16'h0; ps2 = 16'h0; ps3 = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1; rst = 1'b0;
    set_ps_lit();
    trig(8'hF9); collect(0, 0, -1, 0);
    trig(8'hF9); collect(1, 0, -1, 0);
    trig(8'hF9); collect(0, 0, -1, 1);
    set_ps_lit();
    trig(8'hF9); collect(0, 0, 3, 1);
    chk("overrun_set", overrun, 1);
    set_ps_lit();
    trig(8'hF9); collect(2, 0, -1, 0);
    chk("overrun_clr", overrun, 0);
    trig(8'hF9); collect(0, 4, -1, 0);
    repeat (5) begin @(negedge clk); chk("hold_once", tx_valid, 0); end
    trig(8'hFE);
    @(posedge clk); #1; uart_rw = 1'b0;
    repeat (4) begin @(negedge clk); chk("fe_ignored", tx_valid, 0); end
    trig(8'hF9);
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(posedge clk); #1; uart_rw = 1'b0; tx_ready = 1'b1;
      @(negedge clk);
      if (tx_valid && tx_ready) n++;
    end
    chk("pre_rst_count", n, 5);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (5) begin @(negedge clk); chk("post_rst_idle", tx_valid, 0); end
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      uart_rw = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 3))
        0, 1: uart_in = 8'hF9;
        2: uart_in = 8'hFE;
        default: uart_in = 8'($urandom);
      endcase
      tx_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) begin
        ps0 = 16'($urandom); ps1 = 16'($urandom); ps2 = 16'($urandom); ps3 = 16'($urandom);
      end
      rst = $urandom_range(0, 299) == 0;
    end
    @(posedge clk); #1; rst = 1'b0; uart_rw = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_readback_module.md
RESULT_READBACK_MODULE -- requirements
Module: result_readback_module

Interface
REQ-001 Parameter: READ_ADDR, 8'hF9, command byte that triggers a result readback.
REQ-002 Parameter: SEND_CHECKSUM, 1, when 1 a ninth XOR-checksum byte follows the 8 data bytes.
REQ-003 Clock  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 uart_rw  input  1  command-bus write strobe from the CPU.
REQ-006 uart_in  input  8  command-bus byte, valid while uart_rw=1.
REQ-007 ps_data0..ps_data3  input  16 each  systolic array bottom partial-sum outputs, columns 0..3.
REQ-008 tx_data  output  8  readback byte to CPU side.
REQ-009 tx_valid  output  1  tx_data holds a byte awaiting acceptance.
REQ-010 tx_ready  input  1  CPU side accepts the byte this cycle when tx_valid=1.
REQ-011 busy  output  1  high from capture until the last byte is accepted.
REQ-012 done  output  1  one-cycle pulse after the last byte is accepted.
REQ-013 overrun  output  1  sticky; a trigger arrived while busy.

Function
REQ-014 Trigger SHALL be the rising edge of uart_rw (uart_rw=1 and registered previous uart_rw=0) with uart_in==READ_ADDR; multi-cycle strobes count once.
REQ-015 States: IDLE, SEND; IDLE->SEND on trigger; SEND->IDLE on acceptance of final byte.
REQ-016 On trigger in cycle N, ps_data0..3 sampled in cycle N SHALL be captured into a 64-bit snapshot; tx_valid=1 and busy=1 from cycle N+1.
REQ-017 Snapshot SHALL be unaffected by later ps_data changes until the next accepted trigger.
REQ-018 Byte order: ps0[7:0], ps0[15:8], ps1[7:0], ps1[15:8], ps2[7:0], ps2[15:8], ps3[7:0], ps3[15:8], then checksum if SEND_CHECKSUM=1.
REQ-019 Checksum SHALL be the XOR of the 8 preceding data bytes.
REQ-020 A byte is transferred on each cycle with tx_valid=1 and tx_ready=1; byte index (4-bit, 0..8) advances by one per transfer, no wrap past the final index.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable.
REQ-022 tx_ready=1 continuously SHALL yield one byte per cycle, 8 or 9 consecutive cycles.
REQ-023 After the final transfer in cycle M: tx_valid=0, busy=0, done=1 in cycle M+1; done=0 in cycle M+2.
REQ-024 Trigger while busy, including the final-transfer cycle, SHALL be ignored for data and SHALL set overrun.
REQ-025 overrun SHALL clear on the next trigger accepted in IDLE.
REQ-026 Non-matching uart_in bytes SHALL have no effect; tx_data=8'h00 whenever tx_valid=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, overrun=0, byte index 0, snapshot 0, previous uart_rw 0.
REQ-028 rst mid-transfer SHALL abort the sequence; no byte is resumed after release.
REQ-029 After rst deasserts, a trigger is accepted only on a fresh uart_rw rising edge.

Structure
REQ-030 Command addresses (8'hFF right shift, 8'hFE B shift, 8'hFD bottom shift, 8'hFC A data, 8'hFB B data, 8'hFA PS data, 8'hF9 readback) and readback byte count SHALL live in shared package sa_ctrl_pkg.
REQ-031 State enum SHALL live in sa_ctrl_pkg.
REQ-032 One sub-module, cmd_strobe_detect (uart_rw edge detect plus address compare, parameterised by address), SHALL be used.

Verification
REQ-033 ps0..3=16'h1234,16'h5678,16'h9ABC,16'hDEF0, trigger F9, tx_ready=1 -> bytes 34,12,78,56,BC,9A,F0,DE,checksum 00 on consecutive cycles; done 1 cycle later.
REQ-034 Same data, tx_ready toggling 1/0 -> same 9 bytes, tx_data stable during every stall, no byte lost or duplicated.
REQ-035 ps_data changed to 16'hFFFF one cycle after trigger -> output still 34,12,... from the snapshot.
REQ-036 Second F9 during byte 3 -> overrun=1, sequence unchanged; next F9 in IDLE -> overrun=0, new readback.
REQ-037 uart_rw held high 5 cycles with F9 -> exactly one sequence; uart_in=FE with uart_rw pulse -> no tx_valid.
REQ-038 rst pulse at byte 5 -> all outputs at reset values in the same cycle; no tx_valid after release without a new trigger.
